// File: rtl/regf_cmd_pkg.sv
// Shared command-bus definitions for initiators talking to the BER register file.
// Holds the opcode map, the command-word bit positions, the BER word-select
// encoding, and a helper that builds a BER read-select payload.
package regf_cmd_pkg;

  localparam logic [7:0] OPC_RST_SOFT = 8'h01;
  localparam logic [7:0] OPC_EN_RX    = 8'h02;
  localparam logic [7:0] OPC_LOG_SEL  = 8'h03;
  localparam logic [7:0] OPC_RAM_RD   = 8'h04;
  localparam logic [7:0] OPC_LOG_BER  = 8'h05;
  localparam logic [7:0] OPC_BER_RD   = 8'h06;

  localparam int unsigned STROBE_BIT = 23;
  localparam int unsigned RD_EN_BIT  = 16;
  localparam int unsigned PAYLOAD_W  = STROBE_BIT;

  // 32-bit halves of the four BER accumulators, low word first
  typedef enum logic [2:0] {
    BER_ERR_I_LO = 3'd0,
    BER_ERR_I_HI = 3'd1,
    BER_BIT_I_LO = 3'd2,
    BER_BIT_I_HI = 3'd3,
    BER_ERR_Q_LO = 3'd4,
    BER_ERR_Q_HI = 3'd5,
    BER_BIT_Q_LO = 3'd6,
    BER_BIT_Q_HI = 3'd7
  } ber_sel_e;

  function automatic logic [PAYLOAD_W-1:0] ber_rd_payload(input ber_sel_e sel);
    logic [PAYLOAD_W-1:0] p;
    p            = '0;
    p[RD_EN_BIT] = 1'b1;
    p[2:0]       = sel;
    return p;
  endfunction

endpackage

// File: rtl/gpio_cmd_writer.sv
// Emits one command write on the GPIO word bus: HOLD_CYCLES cycles with the
// strobe set, then a gap of (1 + i_tail) cycles with the strobe clear and the
// opcode/payload still driven. o_ack pulses in the last gap cycle; a new i_go
// may be issued in that same cycle for back-to-back writes. With no new go the
// bus returns to 0.
//  clk, i_reset_n   clock, synchronous active-low reset
//  i_go             start a write (only while idle or on o_ack)
//  i_opcode         opcode field [31:24]
//  i_payload        payload field [22:0]
//  i_tail           extra gap cycles appended after the single gap cycle
//  o_word           command word to the register file
//  o_gap            high in every gap/tail cycle
//  o_ack            high in the final gap/tail cycle
module gpio_cmd_writer
  import regf_cmd_pkg::*;
#(
  parameter int unsigned NBT_GPIOS   = 32,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  input  logic                 i_go,
  input  logic [7:0]           i_opcode,
  input  logic [PAYLOAD_W-1:0] i_payload,
  input  logic [CNT_W-1:0]     i_tail,
  output logic [NBT_GPIOS-1:0] o_word,
  output logic                 o_gap,
  output logic                 o_ack
);

  typedef enum logic [1:0] {W_IDLE, W_HOLD, W_GAP} phase_e;

  phase_e               r_phase;
  logic [NBT_GPIOS-1:0] r_word;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_tail;

  // One down-counter serves both the strobe hold and the gap/tail stretch.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_phase <= W_IDLE;
      r_word  <= '0;
      r_cnt   <= '0;
      r_tail  <= '0;
    end else if (i_go) begin
      r_phase <= W_HOLD;
      r_word  <= {i_opcode, 1'b1, i_payload};
      r_cnt   <= CNT_W'(HOLD_CYCLES - 1);
      r_tail  <= i_tail;
    end else begin
      unique case (r_phase)
        W_HOLD: begin
          if (r_cnt == '0) begin
            r_word[STROBE_BIT] <= 1'b0;
            r_cnt              <= r_tail;
            r_phase            <= W_GAP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        W_GAP: begin
          if (r_cnt == '0) begin
            r_word  <= '0;
            r_phase <= W_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_word = r_word;
  assign o_gap  = (r_phase == W_GAP);
  assign o_ack  = (r_phase == W_GAP) && (r_cnt == '0);

endmodule

// File: rtl/ber_snapshot_seq.sv
// Takes an atomic snapshot of the four 64-bit BER accumulators over the GPIO
// command bus: arm and latch the log, clear the flag, read the eight 32-bit
// halves one by one into a shadow, release the read enable, then commit the
// shadow to the outputs together with a one-cycle o_done.
//  clk, i_reset_n     clock, synchronous active-low reset
//  i_start            snapshot request, honoured only in IDLE
//  o_busy             sequence in progress (excludes the o_done cycle)
//  o_done             one-cycle pulse, snapshot outputs valid from here
//  o_accum_*          committed snapshot, held between snapshots
//  o_gpio_to_regf     command word {opcode, strobe, payload}
//  i_regf_to_gpio     readback word from the register file
module ber_snapshot_seq
  import regf_cmd_pkg::*;
#(
  parameter int unsigned NBT_GPIOS          = 32,
  parameter int unsigned NBT_COUNT_BITS_ERR = 64,
  parameter int unsigned HOLD_CYCLES        = 2,
  parameter int unsigned SETTLE_CYCLES      = 2
) (
  input  logic                          clk,
  input  logic                          i_reset_n,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_err_I,
  output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_bit_I,
  output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_err_Q,
  output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_bit_Q,
  output logic [NBT_GPIOS-1:0]          o_gpio_to_regf,
  input  logic [NBT_GPIOS-1:0]          i_regf_to_gpio
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + SETTLE_CYCLES + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_LATCH, S_DISARM, S_SEL, S_SETTLE, S_RELEASE, S_DONE
  } state_e;

  state_e                          r_state;
  logic                            r_busy;
  logic                            r_done;
  logic [2:0]                      r_idx;
  logic [NBT_GPIOS-1:0]            r_shadow [8];
  logic [NBT_COUNT_BITS_ERR-1:0]   r_err_I, r_bit_I, r_err_Q, r_bit_Q;

  logic                 w_go;
  logic [7:0]           w_opcode;
  logic [PAYLOAD_W-1:0] w_payload;
  logic [CNT_W-1:0]     w_tail;
  logic                 w_gap;
  logic                 w_ack;

  gpio_cmd_writer #(
    .NBT_GPIOS   (NBT_GPIOS),
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_writer (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_go      (w_go),
    .i_opcode  (w_opcode),
    .i_payload (w_payload),
    .i_tail    (w_tail),
    .o_word    (o_gpio_to_regf),
    .o_gap     (w_gap),
    .o_ack     (w_ack)
  );

  // Next write is issued on the ack of the current one so writes run back to
  // back; the SETTLE stretch is the writer's gap tail on each select.
  always_comb begin
    w_go      = 1'b0;
    w_opcode  = OPC_LOG_BER;
    w_payload = '0;
    w_tail    = '0;
    unique case (r_state)
      S_IDLE: if (i_start) begin
        w_go      = 1'b1;
        w_payload = PAYLOAD_W'(1);
      end
      S_ARM: if (w_ack) begin
        w_go      = 1'b1;
        w_payload = PAYLOAD_W'(1);
      end
      S_LATCH: if (w_ack) w_go = 1'b1;
      S_DISARM: if (w_ack) begin
        w_go      = 1'b1;
        w_opcode  = OPC_BER_RD;
        w_payload = ber_rd_payload(ber_sel_e'(r_idx));
        w_tail    = CNT_W'(SETTLE_CYCLES);
      end
      S_SETTLE: if (w_ack) begin
        w_go     = 1'b1;
        w_opcode = OPC_BER_RD;
        // after the last half, a zero payload drops the read enable
        if (r_idx != 3'd7) begin
          w_payload = ber_rd_payload(ber_sel_e'(r_idx + 3'd1));
          w_tail    = CNT_W'(SETTLE_CYCLES);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
      r_err_I <= '0;
      r_bit_I <= '0;
      r_err_Q <= '0;
      r_bit_Q <= '0;
      for (int unsigned i = 0; i < 8; i++) r_shadow[i] <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: if (i_start) begin
          r_state <= S_ARM;
          r_busy  <= 1'b1;
          r_idx   <= '0;
        end
        S_ARM:    if (w_ack) r_state <= S_LATCH;
        S_LATCH:  if (w_ack) r_state <= S_DISARM;
        S_DISARM: if (w_ack) r_state <= S_SEL;
        S_SEL:    if (w_gap) r_state <= S_SETTLE;
        S_SETTLE: if (w_ack) begin
          r_shadow[r_idx] <= i_regf_to_gpio;
          r_idx           <= r_idx + 3'd1;
          r_state         <= (r_idx == 3'd7) ? S_RELEASE : S_SEL;
        end
        S_RELEASE: if (w_ack) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_err_I <= {r_shadow[1], r_shadow[0]};
          r_bit_I <= {r_shadow[3], r_shadow[2]};
          r_err_Q <= {r_shadow[5], r_shadow[4]};
          r_bit_Q <= {r_shadow[7], r_shadow[6]};
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_accum_err_I = r_err_I;
  assign o_accum_bit_I = r_bit_I;
  assign o_accum_err_Q = r_err_Q;
  assign o_accum_bit_Q = r_bit_Q;

endmodule

// File: tb/tb_ber_snapshot_seq.sv
// Two DUTs share one clock: index 0 uses HOLD=2/SETTLE=2, index 1 uses
// HOLD=1/SETTLE=1. Each DUT talks to its own behavioural register file that
// latches the live accumulators on a LOG_BER write seen while the log flag is
// already set, and returns the selected 32-bit half while read-enabled.
module tb_ber_snapshot_seq;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        start [2];
  logic        busy  [2];
  logic        done  [2];
  logic [31:0] gpio  [2];
  logic [63:0] acc   [2][4];
  logic [63:0] live  [2][4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned HC = (g == 0) ? 2 : 1;
    localparam int unsigned SC = (g == 0) ? 2 : 1;

    logic [63:0] m_lat [4];
    logic        m_flag  = 1'b0;
    logic        m_rden  = 1'b0;
    logic        m_prev  = 1'b0;
    logic [2:0]  m_sel   = 3'd0;
    logic [31:0] m_rdata = 32'd0;

    ber_snapshot_seq #(
      .NBT_GPIOS          (32),
      .NBT_COUNT_BITS_ERR (64),
      .HOLD_CYCLES        (HC),
      .SETTLE_CYCLES      (SC)
    ) u_dut (
      .clk            (clk),
      .i_reset_n      (rst_n[g]),
      .i_start        (start[g]),
      .o_busy         (busy[g]),
      .o_done         (done[g]),
      .o_accum_err_I  (acc[g][0]),
      .o_accum_bit_I  (acc[g][1]),
      .o_accum_err_Q  (acc[g][2]),
      .o_accum_bit_Q  (acc[g][3]),
      .o_gpio_to_regf (gpio[g]),
      .i_regf_to_gpio (m_rdata)
    );

    // register-file model: acts on the rising edge of the strobe bit
    always @(posedge clk) begin
      m_prev <= gpio[g][23];
      if (gpio[g][23] && !m_prev) begin
        if (gpio[g][31:24] == 8'h05) begin
          if (gpio[g][0]) begin
            if (m_flag) for (int i = 0; i < 4; i++) m_lat[i] <= live[g][i];
            m_flag <= 1'b1;
          end else begin
            m_flag <= 1'b0;
          end
        end else if (gpio[g][31:24] == 8'h06) begin
          m_rden <= gpio[g][16];
          m_sel  <= gpio[g][2:0];
        end
      end
      if (m_rden) m_rdata <= m_sel[0] ? m_lat[m_sel[2:1]][63:32] : m_lat[m_sel[2:1]][31:0];
      else        m_rdata <= 32'd0;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input int d);
    check("rst_word", {32'd0, gpio[d]}, 64'd0);
    check("rst_busy", {63'd0, busy[d]}, 64'd0);
    check("rst_done", {63'd0, done[d]}, 64'd0);
    for (int i = 0; i < 4; i++) check("rst_acc", acc[d][i], 64'd0);
  endtask

  task automatic set_live(input int d, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, input logic [63:0] e);
    live[d][0] = a; live[d][1] = b; live[d][2] = c; live[d][3] = e;
  endtask

  task automatic set_live_rand(input int d);
    for (int i = 0; i < 4; i++) live[d][i] = {$urandom, $urandom};
  endtask

  // Called at #1 after an edge. abort_at >= 0 asserts reset in that cycle
  // (so the DUT sees it at the following edge, start + abort_at + 1).
  task automatic run_snap(input int d, input bit busy_starts, input int abort_at);
    int          hc, sc, len;
    logic [31:0] exp_q [$];
    logic [7:0]  opc;
    logic [22:0] pay;
    int          gap;
    logic [63:0] e [4];
    logic [63:0] prev_acc [4];

    hc = (d == 0) ? 2 : 1;
    sc = (d == 0) ? 2 : 1;
    for (int w = 0; w < 12; w++) begin
      if (w < 3) begin
        opc = 8'h05; pay = (w < 2) ? 23'd1 : 23'd0; gap = 1;
      end else if (w < 11) begin
        opc = 8'h06; pay = 23'h10000 | 23'(w - 3); gap = 1 + sc;
      end else begin
        opc = 8'h06; pay = 23'd0; gap = 1;
      end
      repeat (hc)  exp_q.push_back({opc, 1'b1, pay});
      repeat (gap) exp_q.push_back({opc, 1'b0, pay});
    end
    len = exp_q.size();
    for (int i = 0; i < 4; i++) begin
      e[i]        = live[d][i];
      prev_acc[i] = acc[d][i];
    end

    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    for (int k = 0; k < len; k++) begin
      check("word", {32'd0, gpio[d]}, {32'd0, exp_q[k]});
      check("busy", {63'd0, busy[d]}, 64'd1);
      check("done_early", {63'd0, done[d]}, 64'd0);
      for (int i = 0; i < 4; i++) check("acc_hold", acc[d][i], prev_acc[i]);
      if (d == 0 && k == 0)  check("word_arm",  {32'd0, gpio[d]}, 64'h0580_0001);
      if (d == 0 && k == 2)  check("word_gap0", {32'd0, gpio[d]}, 64'h0500_0001);
      if (d == 0 && k == 24) check("word_sel3", {32'd0, gpio[d]}, 64'h0681_0003);
      if (d == 0 && k == 51) check("word_rel",  {32'd0, gpio[d]}, 64'h0600_0000);
      start[d] = busy_starts && (k == 5 || k == 40);
      if (k == abort_at) begin
        rst_n[d] = 1'b0;
        tick();
        rst_n[d] = 1'b1;
        start[d] = 1'b0;
        check_idle_zero(d);
        for (int c = 0; c < 60; c++) begin
          tick();
          check("abort_done", {63'd0, done[d]}, 64'd0);
          check("abort_word", {32'd0, gpio[d]}, 64'd0);
        end
        return;
      end
      tick();
    end
    start[d] = 1'b0;

    check("done", {63'd0, done[d]}, 64'd1);
    check("busy_at_done", {63'd0, busy[d]}, 64'd0);
    check("word_at_done", {32'd0, gpio[d]}, 64'd0);
    check("err_I", acc[d][0], e[0]);
    check("bit_I", acc[d][1], e[1]);
    check("err_Q", acc[d][2], e[2]);
    check("bit_Q", acc[d][3], e[3]);
    start[d] = busy_starts;
    tick();
    start[d] = 1'b0;
    check("done_pulse", {63'd0, done[d]}, 64'd0);
    for (int i = 0; i < 4; i++) check("acc_keep", acc[d][i], e[i]);
    tick();
    check("idle_busy", {63'd0, busy[d]}, 64'd0);
    check("idle_word", {32'd0, gpio[d]}, 64'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      start[d] = 1'b1;
      for (int i = 0; i < 4; i++) live[d][i] = 64'd0;
    end
    // reset held for three cycles with start asserted
    repeat (3) begin
      tick();
      for (int d = 0; d < 2; d++) check_idle_zero(d);
    end
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1;
      start[d] = 1'b0;
    end
    tick();

    // directed snapshot on both timing configurations
    for (int d = 0; d < 2; d++) begin
      set_live(d, 64'h0000_0001_0000_0002, 64'hA, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
      run_snap(d, 1'b0, -1);
    end

    // starts while busy and during done are ignored; next start runs normally
    set_live_rand(0);
    run_snap(0, 1'b1, -1);
    set_live_rand(0);
    run_snap(0, 1'b0, -1);

    // reset during the readback phase, then a clean snapshot
    set_live_rand(0);
    run_snap(0, 1'b0, 29);
    set_live_rand(0);
    run_snap(0, 1'b0, -1);

    // randomized values and idle gaps
    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < 2; d++) begin
        repeat ($urandom_range(0, 5)) begin
          tick();
          check("gap_word", {32'd0, gpio[d]}, 64'd0);
        end
        set_live_rand(d);
        run_snap(d, r[0], -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
